// File: rtl/motor_cmd_sched.sv
// Motor command scheduler: arbitrates manual and autonomous wheel commands,
// stops on auto silence, and issues changes plus periodic keep-alives to the UART TX.
module motor_cmd_sched #(
   parameter int unsigned W              = 8,
   parameter int unsigned REFRESH_CYCLES = 5_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         man_en_i,
   input  logic [W-1:0] man_speed_l_i,
   input  logic [W-1:0] man_speed_r_i,
   input  logic         man_neg_l_i,
   input  logic         man_neg_r_i,
   input  logic         auto_valid_i,
   input  logic [W-1:0] auto_speed_l_i,
   input  logic [W-1:0] auto_speed_r_i,
   input  logic         auto_neg_l_i,
   input  logic         auto_neg_r_i,
   output logic         cmd_valid_o,
   input  logic         cmd_ready_i,
   output logic [W-1:0] cmd_speed_l_o,
   output logic [W-1:0] cmd_speed_r_o,
   output logic         cmd_neg_l_o,
   output logic         cmd_neg_r_o,
   output logic [1:0]   src_o,
   output logic         timeout_o
);

   localparam int unsigned PW = 2 * W + 2;
   localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   // {man_en, speed_l, speed_r, neg_l, neg_r}
   logic [PW:0]   man_meta_q, man_sync_q;
   logic [PW-1:0] auto_q;
   logic [TW-1:0] wd_q;
   logic          timeout_q;

   state_e        state_q;
   logic [PW-1:0] cmd_q;
   logic [PW-1:0] last_q;
   logic          cmd_valid_q;
   logic [RW-1:0] refresh_q;
   logic [1:0]    src_q;

   logic [PW-1:0] tgt;
   logic [1:0]    tgt_src;
   logic          send_trig;

   // Two-flop synchronizer for the asynchronous switch inputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         man_meta_q <= '0;
         man_sync_q <= '0;
      end else begin
         man_meta_q <= {man_en_i, man_speed_l_i, man_speed_r_i, man_neg_l_i, man_neg_r_i};
         man_sync_q <= man_meta_q;
      end
   end

   // Auto latch and saturating watchdog; a strobe wins over expiry in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         auto_q    <= '0;
         wd_q      <= '0;
         timeout_q <= 1'b1;
      end else if (auto_valid_i) begin
         auto_q    <= {auto_speed_l_i, auto_speed_r_i, auto_neg_l_i, auto_neg_r_i};
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else if (wd_q != TW'(TIMEOUT_CYCLES - 1)) begin
         wd_q <= wd_q + TW'(1);
      end else begin
         timeout_q <= 1'b1;
      end
   end

   // Priority target selection: manual, then watchdog stop, then auto latch.
   always_comb begin
      tgt     = auto_q;
      tgt_src = 2'b10;
      if (man_sync_q[PW]) begin
         tgt     = man_sync_q[PW-1:0];
         tgt_src = 2'b01;
      end else if (timeout_q) begin
         tgt     = '0;
         tgt_src = 2'b00;
      end
   end

   assign send_trig = (tgt != last_q) || (refresh_q == RW'(REFRESH_CYCLES - 1));

   // Send FSM with registered payload; target changes during SEND wait for IDLE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cmd_q       <= '0;
         last_q      <= '0;
         cmd_valid_q <= 1'b0;
         refresh_q   <= '0;
         src_q       <= 2'b00;
      end else begin
         src_q <= tgt_src;
         unique case (state_q)
            StIdle: begin
               refresh_q <= refresh_q + RW'(1);
               if (send_trig) begin
                  cmd_q       <= tgt;
                  cmd_valid_q <= 1'b1;
                  state_q     <= StSend;
               end
            end
            StSend: begin
               if (cmd_ready_i) begin
                  last_q      <= cmd_q;
                  cmd_valid_q <= 1'b0;
                  refresh_q   <= '0;
                  state_q     <= StIdle;
               end
            end
         endcase
      end
   end

   assign cmd_valid_o   = cmd_valid_q;
   assign cmd_speed_l_o = cmd_q[PW-1 -: W];
   assign cmd_speed_r_o = cmd_q[W+1 -: W];
   assign cmd_neg_l_o   = cmd_q[1];
   assign cmd_neg_r_o   = cmd_q[0];
   assign src_o         = src_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Scoreboard bench for motor_cmd_sched: stimulus pushes expected transfers
// (payload, source, start cycle); a negedge monitor pops and compares.
module tb_motor_cmd_sched;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       man_en_i = 1'b0;
   logic [7:0] man_speed_l_i = '0, man_speed_r_i = '0;
   logic       man_neg_l_i = 1'b0, man_neg_r_i = 1'b0;
   logic       auto_valid_i = 1'b0;
   logic [7:0] auto_speed_l_i = '0, auto_speed_r_i = '0;
   logic       auto_neg_l_i = 1'b0, auto_neg_r_i = 1'b0;
   logic       cmd_valid_o;
   logic       cmd_ready_i = 1'b1;
   logic [7:0] cmd_speed_l_o, cmd_speed_r_o;
   logic       cmd_neg_l_o, cmd_neg_r_o;
   logic [1:0] src_o;
   logic       timeout_o;

   motor_cmd_sched #(
      .W              (8),
      .REFRESH_CYCLES (16),
      .TIMEOUT_CYCLES (40)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .man_en_i       (man_en_i),
      .man_speed_l_i  (man_speed_l_i),
      .man_speed_r_i  (man_speed_r_i),
      .man_neg_l_i    (man_neg_l_i),
      .man_neg_r_i    (man_neg_r_i),
      .auto_valid_i   (auto_valid_i),
      .auto_speed_l_i (auto_speed_l_i),
      .auto_speed_r_i (auto_speed_r_i),
      .auto_neg_l_i   (auto_neg_l_i),
      .auto_neg_r_i   (auto_neg_r_i),
      .cmd_valid_o    (cmd_valid_o),
      .cmd_ready_i    (cmd_ready_i),
      .cmd_speed_l_o  (cmd_speed_l_o),
      .cmd_speed_r_o  (cmd_speed_r_o),
      .cmd_neg_l_o    (cmd_neg_l_o),
      .cmd_neg_r_o    (cmd_neg_r_o),
      .src_o          (src_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [17:0] pay;
      logic [1:0]  src;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   // Edges since reset release.
   always @(posedge clk_i) cyc <= rst_i ? 0 : cyc + 1;

   function automatic logic [17:0] pk(input logic [7:0] l, input logic [7:0] r,
                                      input logic nl, input logic nr);
      return {l, r, nl, nr};
   endfunction

   task automatic push(input logic [17:0] pay, input logic [1:0] s, input int c);
      exp_t e;
      e.pay = pay;
      e.src = s;
      e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int c);
      int guard = 0;
      while (cyc != c) begin
         @(posedge clk_i);
         #1;
         guard++;
         if (guard > 500) begin
            $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, c);
            $fatal(1, "cycle wait expired");
         end
      end
   endtask

   // Monitor: each rising cmd_valid starts a transfer and pops one expectation;
   // while valid is held the payload must stay at the expected value.
   always @(negedge clk_i) begin
      logic [17:0] pay;
      pay = {cmd_speed_l_o, cmd_speed_r_o, cmd_neg_l_o, cmd_neg_r_o};
      if (cmd_valid_o && !prev_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_send: got payload %0h at cyc %0d, required none", pay, cyc);
         end else begin
            cur = sb.pop_front();
            check("send_payload", 32'(pay), 32'(cur.pay));
            check("send_src", 32'(src_o), 32'(cur.src));
            check("send_cycle", cyc, cur.cyc);
         end
      end else if (cmd_valid_o) begin
         check("hold_payload", 32'(pay), 32'(cur.pay));
      end
      prev_valid = cmd_valid_o;
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("rst_valid", 32'(cmd_valid_o), 0);
      check("rst_speed_l", 32'(cmd_speed_l_o), 0);
      check("rst_speed_r", 32'(cmd_speed_r_o), 0);
      check("rst_negs", 32'({cmd_neg_l_o, cmd_neg_r_o}), 0);
      check("rst_src", 32'(src_o), 0);
      check("rst_timeout", 32'(timeout_o), 1);

      // Keep-alive of the stop target, period 17.
      push(pk(8'h00, 8'h00, 1'b0, 1'b0), 2'b00, 16);
      push(pk(8'h00, 8'h00, 1'b0, 1'b0), 2'b00, 33);
      wait_cyc(15);
      check("no_early_refresh", 32'(cmd_valid_o), 0);

      // Auto strobe with ready low; transfer is held.
      wait_cyc(35);
      check("timeout_before_strobe", 32'(timeout_o), 1);
      auto_speed_l_i = 8'h40; auto_speed_r_i = 8'h20;
      auto_neg_l_i = 1'b1; auto_neg_r_i = 1'b0;
      auto_valid_i = 1'b1;
      cmd_ready_i  = 1'b0;
      push(pk(8'h40, 8'h20, 1'b1, 1'b0), 2'b10, 37);
      wait_cyc(36);
      auto_valid_i = 1'b0;
      check("timeout_cleared", 32'(timeout_o), 0);

      // New auto value while stalled must wait for the handshake.
      wait_cyc(38);
      auto_speed_l_i = 8'h10; auto_speed_r_i = 8'h10;
      auto_neg_l_i = 1'b0; auto_neg_r_i = 1'b0;
      auto_valid_i = 1'b1;
      push(pk(8'h10, 8'h10, 1'b0, 1'b0), 2'b10, 47);
      wait_cyc(39);
      auto_valid_i = 1'b0;
      check("stall_speed_l", 32'(cmd_speed_l_o), 32'h40);
      wait_cyc(45);
      cmd_ready_i = 1'b1;
      wait_cyc(46);
      check("idle_gap", 32'(cmd_valid_o), 0);

      // Refresh of 0x10, then watchdog stop 40 cycles after the strobe at 39.
      push(pk(8'h10, 8'h10, 1'b0, 1'b0), 2'b10, 64);
      push(pk(8'h00, 8'h00, 1'b0, 1'b0), 2'b00, 80);
      wait_cyc(78);
      check("timeout_not_yet", 32'(timeout_o), 0);
      wait_cyc(79);
      check("timeout_set", 32'(timeout_o), 1);
      wait_cyc(80);
      check("stop_src", 32'(src_o), 0);

      // Fresh strobe clears timeout.
      wait_cyc(83);
      auto_speed_l_i = 8'h30; auto_speed_r_i = 8'h05;
      auto_neg_l_i = 1'b0; auto_neg_r_i = 1'b1;
      auto_valid_i = 1'b1;
      push(pk(8'h30, 8'h05, 1'b0, 1'b1), 2'b10, 85);
      wait_cyc(84);
      auto_valid_i = 1'b0;
      check("timeout_reclear", 32'(timeout_o), 0);

      // Manual override, 3-edge latency.
      wait_cyc(87);
      man_en_i = 1'b1;
      man_speed_l_i = 8'h7F; man_speed_r_i = 8'h7F;
      push(pk(8'h7F, 8'h7F, 1'b0, 1'b0), 2'b01, 90);
      wait_cyc(92);
      auto_speed_l_i = 8'h55; auto_speed_r_i = 8'h66;
      auto_neg_l_i = 1'b0; auto_neg_r_i = 1'b0;
      auto_valid_i = 1'b1;
      wait_cyc(93);
      auto_valid_i = 1'b0;
      wait_cyc(94);
      check("override_speed_l", 32'(cmd_speed_l_o), 32'h7F);
      check("override_src", 32'(src_o), 32'h1);

      // Release: latched auto value is resent.
      wait_cyc(95);
      man_en_i = 1'b0;
      push(pk(8'h55, 8'h66, 1'b0, 1'b0), 2'b10, 98);

      // Reset during a stalled SEND.
      wait_cyc(100);
      cmd_ready_i = 1'b0;
      wait_cyc(101);
      auto_speed_l_i = 8'h01; auto_speed_r_i = 8'h02;
      auto_valid_i = 1'b1;
      push(pk(8'h01, 8'h02, 1'b0, 1'b0), 2'b10, 103);
      wait_cyc(102);
      auto_valid_i = 1'b0;
      wait_cyc(104);
      check("send_before_rst", 32'(cmd_valid_o), 1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("rst_drops_valid", 32'(cmd_valid_o), 0);
      check("rst_timeout_set", 32'(timeout_o), 1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      cmd_ready_i = 1'b1;
      push(pk(8'h00, 8'h00, 1'b0, 1'b0), 2'b00, 16);
      wait_cyc(15);
      check("post_rst_no_early", 32'(cmd_valid_o), 0);
      wait_cyc(20);
      check("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/motor_cmd_sched.md
# motor_cmd_sched

Command scheduler in front of the motor UART transmitter (`uart_comm`). It arbitrates between two command sources: manual switch control and an autonomous requester. Manual control has fixed priority. A watchdog forces a stop command when the autonomous source goes silent. A command is issued on every change and re-issued periodically as a keep-alive. The output drives the transmitter's valid/ready payload interface.

## Interface
- W, 8, magnitude width of each wheel speed
- REFRESH_CYCLES, 5_000_000, idle cycles before an unchanged command is re-sent (100 ms at 50 MHz)
- TIMEOUT_CYCLES, 25_000_000, cycles without `auto_valid` before the auto source is treated as stop (500 ms)

- clk  in  1  system clock, 50 MHz; single clock domain
- rst  in  1  synchronous, active-high reset
- man_en  in  1  manual override select; asynchronous (switch)
- man_speed_l, man_speed_r  in  W  manual wheel speeds; asynchronous
- man_neg_l, man_neg_r  in  1  manual reverse flags; asynchronous
- auto_valid  in  1  one-cycle strobe that latches the auto_* fields
- auto_speed_l, auto_speed_r  in  W  autonomous wheel speeds
- auto_neg_l, auto_neg_r  in  1  autonomous reverse flags
- cmd_valid  out  1  payload valid to the transmitter
- cmd_ready  in  1  transmitter accepts the payload
- cmd_speed_l, cmd_speed_r  out  W  issued speeds
- cmd_neg_l, cmd_neg_r  out  1  issued reverse flags
- src  out  2  source of the current target: 00 stop, 01 manual, 10 auto
- timeout  out  1  auto watchdog expired

## Operation
- man_* and man_en pass through a 2-flop synchronizer before use.
- Auto latch:
  - `auto_valid` loads auto_* into the latch.
  - It also clears the watchdog counter and `timeout`.
  - The latch updates even while `man_en` is 1.
- Watchdog:
  - The counter increments every cycle and saturates.
  - At TIMEOUT_CYCLES-1 it sets `timeout`=1.
  - If `auto_valid` arrives in the same cycle, `auto_valid` wins.
- Target (combinational), in priority order:
  - synced man_en=1 → manual fields, src=01
  - else timeout=1 → all zero (stop), src=00
  - else → auto latch, src=10
- Payload is {speed_l, speed_r, neg_l, neg_r}, 2W+2 bits. The last_sent register holds the last accepted payload.
- FSM states: IDLE and SEND.
- IDLE:
  - refresh_cnt increments each cycle.
  - Send trigger: target ≠ last_sent, or refresh_cnt == REFRESH_CYCLES-1.
  - On a trigger: register target into cmd_*, set cmd_valid=1, go to SEND.
- SEND:
  - cmd_* and cmd_valid are held stable.
  - Target changes are ignored.
  - On cmd_valid && cmd_ready at the edge: last_sent ← cmd payload, cmd_valid←0, refresh_cnt←0, go to IDLE.
- A target change during SEND is picked up in IDLE on the following cycle, giving at most one back-to-back resend.
- No arithmetic is performed on speeds; the block only passes values through. Counter widths are $clog2(param+1).

## Timing
- Reset values:
  - cmd_valid=0, all cmd_*=0, last_sent=0, auto latch=0
  - refresh_cnt=0, watchdog=0, src=00, timeout=1
  - state IDLE
- Reset asserted during SEND: cmd_valid drops at the next edge and the transfer is abandoned.
- After reset the target (stop) equals last_sent, so the first transfer is the refresh. cmd_valid rises REFRESH_CYCLES cycles after rst falls.
- Latency:
  - auto_valid at edge N → cmd_valid=1 after edge N+1, when the target changed.
  - man_* change → cmd_valid 3 edges later (2 sync + 1).
- Handshake:
  - cmd_ready is sampled at the edge.
  - Minimum 2 cycles per transfer (1 SEND + 1 IDLE).
  - With cmd_ready tied high and a steady target, the period is REFRESH_CYCLES+1.
- src and timeout are registered; they update the edge after their cause.

## Test plan
Use REFRESH_CYCLES=16 and TIMEOUT_CYCLES=40 for all scenarios.
- Reset, cmd_ready=1, no stimulus:
  - All outputs 0, timeout=1.
  - cmd_valid first pulses 16 cycles after rst release with a zero payload, then every 17 cycles.
- auto_valid pulse with speeds 0x40/0x20, neg_l=1:
  - The next cycle gives cmd_valid=1 with 0x40/0x20 and neg_l=1.
  - The same edge gives src=10 and timeout=0.
- cmd_ready held 0 for 10 cycles while auto_valid loads 0x10/0x10:
  - Payload stays 0x40/0x20 until accepted.
  - One IDLE cycle follows, then cmd_valid with 0x10/0x10.
- No auto_valid for 40 cycles after the last strobe:
  - timeout=1, src=00.
  - A stop command (all zero) is issued on the next cycle.
  - A new auto_valid clears timeout.
- man_en=1 with speeds 0x7F/0x7F:
  - cmd_valid appears 3 cycles later with manual values, src=01.
  - An auto_valid during override changes nothing on cmd_*.
  - Releasing man_en resends the auto latch value.
- rst during SEND with cmd_ready=0:
  - cmd_valid=0 at the next edge and no transfer completes.
  - The next cmd_valid comes 16 cycles after rst release.
